// File: rtl/tdp_ram_be_pipe.sv
// True dual-port RAM with per-lane byte writes, configurable read latency and valid pipeline.
// Optional saturating write-write collision counter when TDP_RAM_COLL_COUNT_EN is defined.
module tdp_ram_be_pipe #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned NUM_ENTRIES  = 2048,
  parameter int unsigned ADDR_WIDTH   = $clog2(NUM_ENTRIES),
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             portA_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] portA_we,
  input  logic [ADDR_WIDTH-1:0]            portA_addr,
  input  logic [DATA_WIDTH-1:0]            portA_din,
  output logic [DATA_WIDTH-1:0]            portA_dout,
  output logic                             portA_valid,
  input  logic                             portB_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] portB_we,
  input  logic [ADDR_WIDTH-1:0]            portB_addr,
  input  logic [DATA_WIDTH-1:0]            portB_din,
  output logic [DATA_WIDTH-1:0]            portB_dout,
  output logic                             portB_valid,
  output logic                             collision
`ifdef TDP_RAM_COLL_COUNT_EN
  ,
  output logic [15:0]                      coll_count
`endif
);

  localparam int unsigned NumBytes = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] Depth = NUM_ENTRIES[ADDR_WIDTH:0];

  logic a_in_range, b_in_range;
  logic a_wr, b_wr, a_rd, b_rd;

  always_comb begin
    a_in_range = {1'b0, portA_addr} < Depth;
    b_in_range = {1'b0, portB_addr} < Depth;
    a_wr       = portA_en & (|portA_we) & a_in_range;
    b_wr       = portB_en & (|portB_we) & b_in_range;
    a_rd       = portA_en & ~(|portA_we);
    b_rd       = portB_en & ~(|portB_we);
  end

  // Memory array ignores reset. B lanes are written first so A wins shared lanes on a collision.
  logic [DATA_WIDTH-1:0] mem_q [NUM_ENTRIES];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NumBytes; i++) begin
      if (b_wr && portB_we[i]) begin
        mem_q[portB_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= portB_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (a_wr && portA_we[i]) begin
        mem_q[portA_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= portA_din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read pipelines: stage 0 is the registered array read (old data on same-cycle writes).
  // Later stages only advance with a valid word, so dout holds between reads.
  logic [DATA_WIDTH-1:0]   a_data_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   b_data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] a_vld_q, b_vld_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        a_data_q[k] <= '0;
      end
      a_vld_q <= '0;
    end else begin
      if (a_rd) begin
        a_data_q[0] <= a_in_range ? mem_q[portA_addr] : '0;
      end
      a_vld_q[0] <= a_rd;
      for (int k = 1; k < READ_LATENCY; k++) begin
        if (a_vld_q[k-1]) begin
          a_data_q[k] <= a_data_q[k-1];
        end
        a_vld_q[k] <= a_vld_q[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        b_data_q[k] <= '0;
      end
      b_vld_q <= '0;
    end else begin
      if (b_rd) begin
        b_data_q[0] <= b_in_range ? mem_q[portB_addr] : '0;
      end
      b_vld_q[0] <= b_rd;
      for (int k = 1; k < READ_LATENCY; k++) begin
        if (b_vld_q[k-1]) begin
          b_data_q[k] <= b_data_q[k-1];
        end
        b_vld_q[k] <= b_vld_q[k-1];
      end
    end
  end

  assign portA_dout  = a_data_q[READ_LATENCY-1];
  assign portA_valid = a_vld_q[READ_LATENCY-1];
  assign portB_dout  = b_data_q[READ_LATENCY-1];
  assign portB_valid = b_vld_q[READ_LATENCY-1];

  logic coll_d, coll_q;

  assign coll_d = a_wr & b_wr & (portA_addr == portB_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;

`ifdef TDP_RAM_COLL_COUNT_EN
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (coll_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign coll_count = cnt_q;
`endif

endmodule

// File: tb/tb_tdp_ram_be_pipe.sv
// Scoreboard bench for tdp_ram_be_pipe: driver updates a plain-array memory model and queues
// expected reads/collisions with their due cycle; a negedge monitor pops and compares.
module tb_tdp_ram_be_pipe;
  localparam int unsigned DW  = 64;
  localparam int unsigned NB  = 8;
  localparam int unsigned N   = 1000;
  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          a_en = 1'b0, b_en = 1'b0;
  logic [NB-1:0] a_we = '0, b_we = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;
  logic [DW-1:0] a_dout, b_dout;
  logic          a_valid, b_valid, collision;
`ifdef TDP_RAM_COLL_COUNT_EN
  logic [15:0]   coll_count;
`endif

  tdp_ram_be_pipe #(
    .DATA_WIDTH  (DW),
    .BYTE_WIDTH  (8),
    .NUM_ENTRIES (N),
    .ADDR_WIDTH  (AW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .portA_en   (a_en),
    .portA_we   (a_we),
    .portA_addr (a_addr),
    .portA_din  (a_din),
    .portA_dout (a_dout),
    .portA_valid(a_valid),
    .portB_en   (b_en),
    .portB_we   (b_we),
    .portB_addr (b_addr),
    .portB_din  (b_din),
    .portB_dout (b_dout),
    .portB_valid(b_valid),
    .collision  (collision)
`ifdef TDP_RAM_COLL_COUNT_EN
    ,
    .coll_count (coll_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic [DW-1:0] model [1 << AW];
  exp_t          q [2][$];
  int            qc [$];
  int            tests = 0;
  int            fails = 0;
  logic          mon_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a < N) ? model[a] : '0;
  endfunction

  task automatic model_wr(input logic [AW-1:0] a, input logic [NB-1:0] we,
                          input logic [DW-1:0] d);
    if (a < N) begin
      for (int i = 0; i < NB; i++) begin
        if (we[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
      end
    end
  endtask

  // One cycle of stimulus on both ports; expectations derived before writes (read-first).
  task automatic step(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic be, input logic [NB-1:0] bwe,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd, input logic rst);
    exp_t e;
    a_en = ae; a_we = awe; a_addr = aa; a_din = ad;
    b_en = be; b_we = bwe; b_addr = ba; b_din = bd;
    reset = rst;
    if (!rst) begin
      if (ae && awe == '0) begin
        e.data = model_rd(aa); e.due = cyc + LAT; q[0].push_back(e);
      end
      if (be && bwe == '0) begin
        e.data = model_rd(ba); e.due = cyc + LAT; q[1].push_back(e);
      end
      if (ae && awe != '0 && be && bwe != '0 && aa == ba && aa < N) qc.push_back(cyc + 1);
    end
    if (be) model_wr(ba, bwe, bd);
    if (ae) model_wr(aa, awe, ad);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  // Monitor
  logic [DW-1:0] last [2];
  int            cnt_exp = 0;

  initial begin
    exp_t          e;
    logic          vld [2];
    logic [DW-1:0] dat [2];
    logic          ce;
    string         pn;
    last[0] = '0;
    last[1] = '0;
    forever begin
      @(negedge clock);
      if (mon_on) begin
        vld[0] = a_valid; vld[1] = b_valid;
        dat[0] = a_dout;  dat[1] = b_dout;
        for (int p = 0; p < 2; p++) begin
          pn = (p == 0) ? "A" : "B";
          if (vld[p]) begin
            if (q[p].size() == 0) begin
              check({pn, "_unexpected_valid"}, 1, 0);
            end else begin
              e = q[p].pop_front();
              check({pn, "_rdata"}, dat[p], e.data);
              check({pn, "_latency_cycle"}, 64'(cyc), 64'(e.due));
              last[p] = e.data;
            end
          end else begin
            if (q[p].size() != 0 && q[p][0].due <= cyc) begin
              void'(q[p].pop_front());
              check({pn, "_missing_valid"}, 0, 1);
            end
            check({pn, "_dout_hold"}, dat[p], last[p]);
          end
        end
        ce = 1'b0;
        if (qc.size() != 0 && qc[0] == cyc) begin
          void'(qc.pop_front());
          ce = 1'b1;
        end
        check("collision", 64'(collision), 64'(ce));
`ifdef TDP_RAM_COLL_COUNT_EN
        if (ce && cnt_exp != 65535) cnt_exp++;
        check("coll_count", 64'(coll_count), 64'(cnt_exp));
`endif
        if (reset) begin
          for (int p = 0; p < 2; p++) begin
            while (q[p].size() != 0 && q[p][q[p].size()-1].due > cyc) void'(q[p].pop_back());
            last[p] = '0;
          end
          while (qc.size() != 0 && qc[qc.size()-1] > cyc) void'(qc.pop_back());
          cnt_exp = 0;
        end
      end
    end
  end

  initial begin
    logic          ae, be, rs;
    logic [NB-1:0] awe, bwe;
    logic [AW-1:0] aa, ba;
    @(posedge clock);
    #1;
    // Zero the array while reset is held; writes must still commit during reset.
    for (int i = 0; i < N / 2; i++) begin
      step(1, 8'hFF, AW'(2*i), '0, 1, 8'hFF, AW'(2*i + 1), '0, 1);
    end
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);
    mon_on = 1'b1;
    check("reset_a_valid", 64'(a_valid), 0);
    check("reset_b_valid", 64'(b_valid), 0);
    check("reset_a_dout", a_dout, 0);
    check("reset_collision", 64'(collision), 0);

    // Basic write/read, byte mask, read-first cross-port, write-write collision
    step(1, 8'hFF, 5, 64'h1122334455667788, 0, '0, '0, '0, 0);
    step(1, 8'h00, 5, '0, 1, 8'h00, 5, '0, 0);
    step(0, '0, '0, '0, 1, 8'h0F, 5, 64'hAAAA_AAAA_AAAA_AAAA, 0);
    step(1, 8'h00, 5, '0, 0, '0, '0, '0, 0);
    step(1, 8'hFF, 9, 64'h1, 1, 8'h00, 9, '0, 0);
    step(0, '0, '0, '0, 1, 8'h00, 9, '0, 0);
    step(1, 8'h03, 7, 64'hFFFF, 1, 8'h0F, 7, 64'hEEEE_EEEE, 0);
    step(1, 8'h00, 7, '0, 1, 8'h00, 7, '0, 0);
    // Boundaries: last valid entry and out-of-range accesses
    step(1, 8'hFF, 999, 64'hDEAD_BEEF_0000_0999, 1, 8'hFF, 1000, 64'h1234, 0);
    step(1, 8'h00, 999, '0, 1, 8'h00, 1000, '0, 0);
    step(1, 8'h00, 1023, '0, 0, '0, '0, '0, 0);
    idle(LAT + 2);

    // Streaming reads with reset after the third issue
    for (int i = 0; i < 3; i++) step(1, 8'h00, AW'(i), '0, 0, '0, '0, '0, 0);
    step(1, 8'h00, 3, '0, 0, '0, '0, '0, 1);
    idle(LAT + 2);
    for (int i = 0; i < 8; i++) step(1, 8'h00, AW'(i), '0, 1, 8'h00, AW'(7 - i), '0, 0);
    idle(LAT + 2);

    // Randomized traffic on a small hot address set plus the out-of-range tail
    for (int n = 0; n < 3000; n++) begin
      ae  = ($urandom_range(0, 9) < 8);
      be  = ($urandom_range(0, 9) < 8);
      awe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      bwe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      aa  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15));
      ba  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15));
      rs  = ($urandom_range(0, 299) == 0);
      step(ae, awe, aa, {$urandom, $urandom}, be, bwe, ba, {$urandom, $urandom}, rs);
    end
    idle(LAT + 2);

`ifdef TDP_RAM_COLL_COUNT_EN
    step(0, '0, '0, '0, 0, '0, '0, '0, 1);
    for (int n = 0; n < 65540; n++) begin
      step(1, 8'h01, 3, 64'(n), 1, 8'h01, 3, '0, 0);
    end
    idle(2);
    check("coll_count_saturated", 64'(coll_count), 64'hFFFF);
`endif

    idle(LAT + 2);
    check("a_queue_drained", 64'(q[0].size()), 0);
    check("b_queue_drained", 64'(q[1].size()), 0);
    check("coll_queue_drained", 64'(qc.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
